// File: rtl/fp_adder_driver.sv
// Initiator for the serial-operand FP32 adder: issues A then B on a shared bus and queues sums.
// Define FP_ADDER_DRIVER_STATS_EN to add the stat_jobs / stat_dummy counters.
module fp_adder_driver #(
    parameter int RES_DEPTH = 2,
    parameter int TIMEOUT   = 63
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] fp_a,
    input  logic        fp_ready,
    input  logic [31:0] fp_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        err_timeout,
`ifdef FP_ADDER_DRIVER_STATS_EN
    output logic        err_protocol,
    output logic [15:0] stat_jobs,
    output logic [15:0] stat_dummy
`else
    output logic        err_protocol
`endif
);

    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int OCC_W = $clog2(RES_DEPTH + 1);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RES_DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(RES_DEPTH);
    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              busy;
    logic [31:0]       b_hold;
    logic [WD_W-1:0]   watchdog;
    logic              issue;
    logic              proto_err;
    logic              timeout_hit;
    logic              accept;
    logic              push;
    logic              pop;
    logic [31:0]       mem [RES_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_next;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // State register
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state <= SYNC;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            SYNC:    if (fp_ready) state_next = LOAD_A;
            LOAD_A:  state_next = fp_ready ? SYNC : LOAD_B;
            LOAD_B:  state_next = fp_ready ? SYNC : WAIT;
            WAIT: begin
                if (fp_ready)                    state_next = LOAD_A;
                else if (watchdog == WD_LIMIT)   state_next = SYNC;
            end
            default: state_next = SYNC;
        endcase
    end

    // Output / event decode
    always_comb begin
        issue       = 1'b0;
        proto_err   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            SYNC:           issue = fp_ready;
            LOAD_A, LOAD_B: proto_err = fp_ready;
            WAIT: begin
                issue       = fp_ready;
                timeout_hit = !fp_ready && (watchdog == WD_LIMIT);
            end
            default: ;
        endcase
    end

    // Space for a new job is reserved against the occupancy after this cycle's push/pop
    assign push      = issue && busy;
    assign pop       = out_valid && out_ready;
    assign occ_next  = occ + OCC_W'(push) - OCC_W'(pop);
    assign in_ready  = nreset && issue && (occ_next < DEPTH_OCC);
    assign accept    = in_valid && in_ready;
    assign out_valid = (occ != '0);
    assign out_sum   = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            fp_a         <= '0;
            busy         <= 1'b0;
            watchdog     <= '0;
            err_timeout  <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            if (issue) begin
                fp_a <= accept ? in_a : '0;
                busy <= accept;
            end else if (proto_err) begin
                fp_a         <= '0;
                busy         <= 1'b0;
                err_protocol <= 1'b1;
            end else if (state == LOAD_A) begin
                fp_a <= b_hold;
            end else if (state == LOAD_B) begin
                fp_a <= '0;
            end
            if (timeout_hit) begin
                busy        <= 1'b0;
                err_timeout <= 1'b1;
            end
            if (state == LOAD_B)
                watchdog <= '0;
            else if (state == WAIT && !fp_ready)
                watchdog <= watchdog + 1'b1;
        end
    end

    // Operand B is a data register only; its value matters only after an issue
    always_ff @(posedge clock) begin
        if (issue) b_hold <= accept ? in_b : '0;
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= fp_sum;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            occ <= occ_next;
        end
    end

`ifdef FP_ADDER_DRIVER_STATS_EN
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            stat_jobs  <= '0;
            stat_dummy <= '0;
        end else begin
            if (push)             stat_jobs  <= stat_jobs + 1'b1;
            if (issue && !accept) stat_dummy <= stat_dummy + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_adder_driver.sv
// Scoreboard bench for fp_adder_driver with a table-driven serial-operand adder model.
`timescale 1ns/1ps
module tb_fp_adder_driver;

    logic        clock = 1'b0;
    logic        nreset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] fp_a;
    logic        fp_ready;
    logic [31:0] fp_sum;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sum;
    logic        err_timeout;
    logic        err_protocol;
`ifdef FP_ADDER_DRIVER_STATS_EN
    logic [15:0] stat_jobs;
    logic [15:0] stat_dummy;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    logic        stub_ready = 1'b0;
    logic        glitch = 1'b0;

    always #5 clock = ~clock;

    fp_adder_driver #(.RES_DEPTH(2), .TIMEOUT(63)) dut (
        .clock       (clock),
        .nreset      (nreset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .fp_a        (fp_a),
        .fp_ready    (fp_ready),
        .fp_sum      (fp_sum),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .err_timeout (err_timeout),
`ifdef FP_ADDER_DRIVER_STATS_EN
        .err_protocol(err_protocol),
        .stat_jobs   (stat_jobs),
        .stat_dummy  (stat_dummy)
`else
        .err_protocol(err_protocol)
`endif
    );

    // Adder model: hand-computed sums for the directed operand pairs
    function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h00000000_00000000: return 32'h00000000;
            64'h3F800000_40000000: return 32'h40400000;
            64'h3FC00000_BFC00000: return 32'h00000000;
            64'h7FC00000_3F800000: return 32'hFFFFFFFF;
            64'h40000000_40000000: return 32'h40800000;
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    typedef enum logic [1:0] {AD_DELAY, AD_RDY, AD_A, AD_B} ad_t;
    ad_t         ad_st;
    logic [3:0]  ad_cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            ad_st    <= AD_DELAY;
            ad_cnt   <= 4'd4;
            fp_ready <= 1'b0;
            fp_sum   <= '0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            case (ad_st)
                AD_DELAY: begin
                    if (ad_cnt != 0) ad_cnt <= ad_cnt - 1'b1;
                    else if (!stub_ready) begin
                        fp_ready <= 1'b1;
                        fp_sum   <= model_sum(op_a, op_b);
                        ad_st    <= AD_RDY;
                    end
                end
                AD_RDY: begin
                    fp_ready <= glitch;
                    ad_st    <= AD_A;
                end
                AD_A: begin
                    fp_ready <= 1'b0;
                    op_a     <= fp_a;
                    ad_st    <= AD_B;
                end
                default: begin
                    op_b   <= fp_a;
                    ad_cnt <= 4'd3;
                    ad_st  <= AD_DELAY;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, expv);
        end
    endtask

    // Monitor: every accepted result is compared against the scoreboard head
    always @(negedge clock) begin
        if (nreset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: actual=%h required=none", out_sum);
            end else begin
                check("out_sum", out_sum, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                        input bit keep, input bit chk_b);
        int n;
        n = 0;
        @(posedge clock); #1;
        in_valid = 1'b1; in_a = a; in_b = b;
        @(negedge clock);
        while (!in_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("accept", 32'(in_ready), 32'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        if (keep) exp_q.push_back(expv);
        @(posedge clock); #1;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        @(negedge clock);
        check("bus_a", fp_a, a);
        @(negedge clock);
        if (chk_b) check("bus_b", fp_a, b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_fp_a", fp_a, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", out_sum, 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_err_protocol", 32'(err_protocol), 32'd0);
`ifdef FP_ADDER_DRIVER_STATS_EN
        check("rst_stat_jobs", 32'(stat_jobs), 32'd0);
        check("rst_stat_dummy", 32'(stat_dummy), 32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        @(posedge clock); #1 nreset = 1'b0;
        @(negedge clock);
        check_reset_values();
        repeat (2) @(posedge clock);
        #1 nreset = 1'b1;

        send(32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, 1'b1);
        send(32'h3FC00000, 32'hBFC00000, 32'h00000000, 1'b1, 1'b1);
        send(32'h7FC00000, 32'h3F800000, 32'hFFFFFFFF, 1'b1, 1'b1);
        drain();

        // Idle: only dummy operations, nothing reaches the FIFO
        repeat (100) begin
            @(negedge clock);
            check("idle_fp_a", fp_a, 32'd0);
            check("idle_out_valid", 32'(out_valid), 32'd0);
        end
`ifdef FP_ADDER_DRIVER_STATS_EN
        check("stat_jobs", 32'(stat_jobs), 32'd3);
        check("stat_dummy_nonzero", 32'(stat_dummy != 16'd0), 32'd1);
`endif

        // Back-pressure: two results fill the FIFO, later issue points refuse work
        @(posedge clock); #1 out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, 1'b1);
        send(32'h7FC00000, 32'h3F800000, 32'hFFFFFFFF, 1'b1, 1'b1);
        @(posedge clock); #1;
        in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40000000;
        repeat (40) begin
            @(negedge clock);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head", out_sum, 32'h40400000);
        @(posedge clock); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        send(32'h40000000, 32'h40000000, 32'h40800000, 1'b1, 1'b1);
        drain();

        // Timeout: the adder stops answering after the job is issued
        send(32'h3F800000, 32'h40000000, 32'h0, 1'b0, 1'b1);
        @(posedge clock); #1 stub_ready = 1'b1;
        n = 0;
        while (!err_timeout && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("timeout_set", 32'(err_timeout), 32'd1);
        check("timeout_window", 32'(n >= 58 && n <= 70), 32'd1);
        check("timeout_no_push", 32'(out_valid), 32'd0);
        @(posedge clock); #1 stub_ready = 1'b0;
        repeat (20) @(negedge clock);
        check("timeout_no_late_push", 32'(out_valid), 32'd0);
        check("timeout_sticky", 32'(err_timeout), 32'd1);
        send(32'h3FC00000, 32'hBFC00000, 32'h00000000, 1'b1, 1'b1);
        drain();

        // Protocol error: adder pulses ready while the driver is in LOAD_A
        @(posedge clock); #1 glitch = 1'b1;
        send(32'h3FC00000, 32'hBFC00000, 32'h0, 1'b0, 1'b0);
        n = 0;
        while (!err_protocol && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("protocol_set", 32'(err_protocol), 32'd1);
        @(posedge clock); #1 glitch = 1'b0;
        repeat (20) @(negedge clock);
        check("protocol_no_push", 32'(out_valid), 32'd0);
        send(32'h7FC00000, 32'h3F800000, 32'hFFFFFFFF, 1'b1, 1'b1);
        drain();

        // Reset mid-WAIT with a result parked in the FIFO
        @(posedge clock); #1 out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 32'h0, 1'b0, 1'b1);
        send(32'h40000000, 32'h40000000, 32'h0, 1'b0, 1'b1);
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        @(posedge clock); #1 nreset = 1'b0;
        #1 check_reset_values();
        repeat (2) @(posedge clock);
        #1;
        nreset = 1'b1; out_ready = 1'b1;
        send(32'h40000000, 32'h40000000, 32'h40800000, 1'b1, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_adder_driver.md
Name: fp_adder_driver

Overview:
- Initiator for the serial-operand FP32 adder interface: takes operand pairs from an upstream valid/ready stream, presents A then B on the adder's shared 32-bit operand bus, and captures the sum when the adder's ready returns.
- Buffers results in a small FIFO for a downstream valid/ready consumer.
- The adder free-runs, so on every ready pulse that has no job, the driver issues a dummy 0+0 operation and discards its result.
- Sits between the job-dispatch logic and the adder.

Parameters:
- RES_DEPTH, 2: result FIFO entries, minimum 1.
- TIMEOUT, 63: maximum WAIT cycles without fp_ready before the job is abandoned.

Ports:
- clock  in  1  system clock
- nreset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted this cycle
- in_a  in  32  operand A (IEEE-754 single)
- in_b  in  32  operand B
- fp_a  out  32  registered operand bus to adder input a
- fp_ready  in  1  adder ready (high for exactly one cycle per operation)
- fp_sum  in  32  adder sum, valid while fp_ready=1
- out_valid  out  1  result FIFO not empty
- out_ready  in  1  downstream accepts head result
- out_sum  out  32  head result
- err_timeout  out  1  sticky: an in-flight job was abandoned
- err_protocol  out  1  sticky: fp_ready seen in LOAD_A/LOAD_B

Behaviour:
- Reset and clocking: reset nreset, asynchronous, active-low; clock clock.
- Reset values:
  - State SYNC; fp_a=0; busy=0; FIFO empty.
  - out_valid=0; out_sum=0; err_timeout=0; err_protocol=0; watchdog=0.
  - in_ready=0 while nreset is low.
- Issue point: any cycle with fp_ready=1 while in SYNC or WAIT.
- At the issue point:
  - If busy=1, push fp_sum into the FIFO and clear busy.
  - Let occ_next be the FIFO occupancy after this cycle's push and pop.
  - in_ready = issue point && occ_next < RES_DEPTH (combinational).
  - On in_valid && in_ready: fp_a <= in_a, in_b is latched to b_hold, busy <= 1.
  - Otherwise: fp_a <= 0, b_hold <= 0, busy <= 0 (dummy operation).
  - State becomes LOAD_A.
- LOAD_A: fp_a <= b_hold; next state LOAD_B.
- LOAD_B: fp_a <= 0; watchdog cleared; next state WAIT.
- Timing: operand A is on the bus in cycle T+1 and operand B in T+2, where T is the issue cycle.
- WAIT:
  - Watchdog increments every cycle with fp_ready=0.
  - If the watchdog reaches TIMEOUT: set err_timeout, clear busy (job dropped, no FIFO push), go to SYNC.
- SYNC: entered after reset and after a timeout or protocol error. Waits for fp_ready; the first fp_ready cycle is a normal issue point.
- fp_ready=1 in LOAD_A or LOAD_B:
  - Set err_protocol, drop the job (busy <= 0), fp_a <= 0, go to SYNC.
  - in_ready stays 0 that cycle.
- Result FIFO:
  - Pop on out_valid && out_ready.
  - A push and a pop in the same cycle are both honoured, including when full.
  - A push never overflows, because the in_ready rule reserves space.
- Latency: the result is in the FIFO one cycle after the adder's ready pulse. out_valid rises the cycle after capture.
- Throughput: one job per adder operation when out_ready=1.
- Error flags clear only on reset.
- Reset mid-operation returns to the reset values; the adder resets on the same nreset.

Optional Feature:
- FP_ADDER_DRIVER_STATS_EN defined:
  - Adds outputs stat_jobs[15:0], counting FIFO pushes.
  - Adds stat_dummy[15:0], counting dummy issues.
  - Both wrap 0xFFFF->0 and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- 1.0+2.0: in_a=0x3F800000, in_b=0x40000000, out_ready=1 -> out_sum=0x40400000. fp_a shows A then B on the two cycles after the accepting fp_ready.
- Cancellation: 0x3FC00000 + 0xBFC00000 -> out_sum=0x00000000.
- NaN: 0x7FC00000 + 0x3F800000 -> out_sum=0xFFFFFFFF.
- Idle: in_valid=0 for 100 cycles -> fp_a stays 0, out_valid stays 0, stat_dummy>0 when the feature is enabled.
- Back-pressure: with RES_DEPTH=2 and out_ready=0, two jobs complete -> in_ready stays 0 at later fp_ready pulses. Raising out_ready pops 0x40400000, then the next job is accepted.
- Faults:
  - Stub fp_ready low after issue -> err_timeout=1 after 63 WAIT cycles, no FIFO push.
  - Pulse fp_ready in LOAD_A -> err_protocol=1.
  - nreset pulse mid-WAIT -> all outputs return to reset values.
